// File: rtl/battery_adc_sampler_pkg.sv
// Shared definitions for the battery ADC sampler.
// Contents:
//   - Default parameter constants.
//   - Top-level FSM state type.
//   - SPI frame engine phase type.
//   - Low-battery hysteresis helper.
package battery_adc_sampler_pkg;

   localparam int unsigned SCLK_DIV_DEF      = 6;
   localparam int unsigned FRAME_BITS_DEF    = 18;
   localparam int unsigned SAMPLE_PERIOD_DEF = 12000;
   localparam int unsigned AVG_LOG2_DEF      = 3;
   localparam logic [15:0] LOW_THRESH_DEF    = 16'h9000;
   localparam logic [15:0] LOW_HYST_DEF      = 16'h0200;

   typedef enum logic [2:0] {
      StIdle,
      StCsSetup,
      StShift,
      StCsHold,
      StAccum
   } state_e;

   typedef enum logic [1:0] {
      PhIdle,
      PhSetup,
      PhShift,
      PhHold
   } phase_e;

   // Set below thresh, clear at or above thresh+hyst (17-bit so it cannot wrap), else hold.
   function automatic logic hyst_next(input logic        low,
                                      input logic [15:0] avg,
                                      input logic [15:0] thresh,
                                      input logic [15:0] hyst);
      logic [16:0] clr_level;
      clr_level = {1'b0, thresh} + {1'b0, hyst};
      if (avg < thresh) begin
         return 1'b1;
      end else if ({1'b0, avg} >= clr_level) begin
         return 1'b0;
      end else begin
         return low;
      end
   endfunction

endpackage

// File: rtl/battery_adc_sampler_spi_frame.sv
// SPI frame engine for the battery-sense ADC.
// Runs one conversion frame per start pulse:
//   - chip-select setup with SCLK high;
//   - FRAME_BITS SCLK periods, falling edge first, sampling on each rising edge;
//   - chip-select hold with SCLK high.
// The last 16 bits shifted in are the sample.
// Ports:
//   clk_12MHz, reset : system clock, synchronous active-high reset
//   start_i          : begin a frame (only honoured while idle)
//   adc_miso_i       : asynchronous ADC data, synchronised here
//   adc_cs_n_o       : chip select, active low
//   adc_sclk_o       : SPI clock, idles high
//   setup_end_o      : pulse, chip-select setup finished
//   shift_end_o      : pulse, last rising edge taken
//   done_o           : pulse, frame complete (chip select released on this edge)
//   data_o           : sample of the most recent frame, stable until the next frame shifts
module battery_adc_sampler_spi_frame
   import battery_adc_sampler_pkg::*;
#(
   parameter int unsigned SCLK_DIV   = SCLK_DIV_DEF,
   parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) (
   input  logic        clk_12MHz,
   input  logic        reset,
   input  logic        start_i,
   input  logic        adc_miso_i,
   output logic        adc_cs_n_o,
   output logic        adc_sclk_o,
   output logic        setup_end_o,
   output logic        shift_end_o,
   output logic        done_o,
   output logic [15:0] data_o
);

   localparam int unsigned DivW = $clog2(SCLK_DIV);
   localparam int unsigned BitW = $clog2(FRAME_BITS + 1);

   phase_e            phase_q, phase_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [BitW-1:0]   bits_q, bits_d;
   logic [15:0]       sreg_q, sreg_d;
   logic              cs_n_q, cs_n_d;
   logic              sclk_q, sclk_d;
   logic              miso_meta_q, miso_sync_q;
   logic              half_end;

   always_comb begin
      phase_d     = phase_q;
      div_d       = div_q;
      bits_d      = bits_q;
      sreg_d      = sreg_q;
      cs_n_d      = cs_n_q;
      sclk_d      = sclk_q;
      setup_end_o = 1'b0;
      shift_end_o = 1'b0;
      done_o      = 1'b0;
      half_end    = (div_q == DivW'(SCLK_DIV - 1));

      case (phase_q)
         PhIdle: begin
            if (start_i) begin
               phase_d = PhSetup;
               cs_n_d  = 1'b0;
               sclk_d  = 1'b1;
               div_d   = '0;
               bits_d  = '0;
            end
         end
         PhSetup: begin
            if (half_end) begin
               div_d       = '0;
               sclk_d      = 1'b0;
               phase_d     = PhShift;
               setup_end_o = 1'b1;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         PhShift: begin
            if (half_end) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               // sclk currently low: this edge is a rising edge, take a bit.
               if (!sclk_q) begin
                  sreg_d = {sreg_q[14:0], miso_sync_q};
                  bits_d = bits_q + BitW'(1);
                  if (bits_q == BitW'(FRAME_BITS - 1)) begin
                     phase_d     = PhHold;
                     shift_end_o = 1'b1;
                  end
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         PhHold: begin
            if (half_end) begin
               cs_n_d  = 1'b1;
               phase_d = PhIdle;
               done_o  = 1'b1;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         default: phase_d = PhIdle;
      endcase
   end

   always_ff @(posedge clk_12MHz) begin
      if (reset) begin
         phase_q     <= PhIdle;
         div_q       <= '0;
         bits_q      <= '0;
         sreg_q      <= '0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b1;
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         div_q       <= div_d;
         bits_q      <= bits_d;
         sreg_q      <= sreg_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         miso_meta_q <= adc_miso_i;
         miso_sync_q <= miso_meta_q;
      end
   end

   assign adc_cs_n_o = cs_n_q;
   assign adc_sclk_o = sclk_q;
   assign data_o     = sreg_q;

endmodule

// File: rtl/battery_adc_sampler.sv
// Battery voltage sampler.
// Periodically reads the battery-sense ADC over SPI, box-car averages 2**AVG_LOG2 samples
// and publishes the average plus a low-battery flag with hysteresis.
// Ports:
//   clk_12MHz, reset : system clock, synchronous active-high reset
//   adc_cs_n         : ADC chip select, active low
//   adc_sclk         : SPI clock, idles high
//   adc_miso         : ADC data (asynchronous), MSB first
//   battery_voltage  : latest average in raw ADC counts, changes only when a new average is published
//   sample_valid     : sticky, set when the first average is published
//   low_battery      : low-voltage flag with hysteresis
module battery_adc_sampler
   import battery_adc_sampler_pkg::*;
#(
   parameter int unsigned SCLK_DIV      = SCLK_DIV_DEF,
   parameter int unsigned FRAME_BITS    = FRAME_BITS_DEF,
   parameter int unsigned SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
   parameter int unsigned AVG_LOG2      = AVG_LOG2_DEF,
   parameter logic [15:0] LOW_THRESH    = LOW_THRESH_DEF,
   parameter logic [15:0] LOW_HYST      = LOW_HYST_DEF
) (
   input  logic        clk_12MHz,
   input  logic        reset,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   input  logic        adc_miso,
   output logic [15:0] battery_voltage,
   output logic        sample_valid,
   output logic        low_battery
);

   localparam int unsigned PerW = $clog2(SAMPLE_PERIOD);
   localparam int unsigned AccW = 16 + AVG_LOG2;
   // Keep a 1-bit counter when averaging is disabled; it simply never leaves 0.
   localparam int unsigned CntW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

   state_e            state_q, state_d;
   logic [PerW-1:0]   period_q, period_d;
   logic [AccW-1:0]   acc_q, acc_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [15:0]       volt_q, volt_d;
   logic              valid_q, valid_d;
   logic              low_q, low_d;

   logic              tick;
   logic              start;
   logic              setup_end, shift_end, done;
   logic [15:0]       frame_data;
   logic [AccW-1:0]   sum;
   logic [15:0]       avg;
   logic              cnt_wrap;

   battery_adc_sampler_spi_frame #(
      .SCLK_DIV   (SCLK_DIV),
      .FRAME_BITS (FRAME_BITS)
   ) u_spi_frame (
      .clk_12MHz   (clk_12MHz),
      .reset       (reset),
      .start_i     (start),
      .adc_miso_i  (adc_miso),
      .adc_cs_n_o  (adc_cs_n),
      .adc_sclk_o  (adc_sclk),
      .setup_end_o (setup_end),
      .shift_end_o (shift_end),
      .done_o      (done),
      .data_o      (frame_data)
   );

   always_comb begin
      tick     = (period_q == PerW'(SAMPLE_PERIOD - 1));
      period_d = tick ? '0 : period_q + PerW'(1);

      state_d  = state_q;
      start    = 1'b0;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      volt_d   = volt_q;
      valid_d  = valid_q;
      low_d    = low_q;

      sum      = acc_q + AccW'(frame_data);
      avg      = 16'(sum >> AVG_LOG2);
      cnt_wrap = (AVG_LOG2 == 0) ? 1'b1 : (&cnt_q);

      case (state_q)
         // Ticks seen in any other state are dropped.
         StIdle: begin
            if (tick) begin
               start   = 1'b1;
               state_d = StCsSetup;
            end
         end
         StCsSetup: if (setup_end) state_d = StShift;
         StShift:   if (shift_end) state_d = StCsHold;
         StCsHold:  if (done)      state_d = StAccum;
         StAccum: begin
            cnt_d = cnt_wrap ? '0 : cnt_q + CntW'(1);
            if (cnt_wrap) begin
               volt_d  = avg;
               acc_d   = '0;
               valid_d = 1'b1;
               low_d   = hyst_next(low_q, avg, LOW_THRESH, LOW_HYST);
            end else begin
               acc_d = sum;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_12MHz) begin
      if (reset) begin
         state_q  <= StIdle;
         period_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         volt_q   <= '0;
         valid_q  <= 1'b0;
         low_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         volt_q   <= volt_d;
         valid_q  <= valid_d;
         low_q    <= low_d;
      end
   end

   assign battery_voltage = volt_q;
   assign sample_valid    = valid_q;
   assign low_battery     = low_q;

endmodule
